data_mem_lat: RTL and testbench
===============================

Name: data_mem_lat

Overview:
Parametrised successor to the single-cycle data memory. It is a word-organised data RAM with per-byte write enables, a configurable access latency, and a one-cycle ready/error response handshake. It sits on the core's LSU data port. The core stalls until ready_o is high.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; byte address space is DEPTH_WORDS*4; power of two, at least 2
LATENCY, 1, cycles from the accepting edge to the response; at least 1
IDLE_VALUE, 32'hFA11_1EAF, read_data_o value after reset and after any write response
ERR_VALUE, 32'hDEAD_BEEF, read_data_o value on an error response

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  synchronous reset, active-high
mem_req_i  in  1  access request; sampled only in IDLE
write_enable_i  in  1  1 = write, 0 = read
byte_enable_i  in  4  write byte lanes; ignored for reads
addr_i  in  32  byte address
write_data_i  in  32  write data
read_data_o  out  32  read data; valid when ready_o=1
ready_o  out  1  one-cycle response pulse
err_o  out  1  qualifies ready_o; access faulted

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: state=IDLE, counter=0, ready_o=0, err_o=0, read_data_o=IDLE_VALUE. RAM contents are not reset.
- Reset mid-access: the access is aborted. No write takes effect and no ready_o pulse is produced.
- FSM has two states, IDLE and WAIT.
- Acceptance: a request is accepted at the edge where state=IDLE and mem_req_i=1. At that edge, addr, we, be and wdata are captured.
  - LATENCY=1: the access is performed at the accepting edge.
  - LATENCY>1: go to WAIT with cnt=LATENCY-2. In WAIT, cnt decrements each edge. At the edge where cnt==0, the access is performed and state returns to IDLE.
- Response timing: ready_o is high for exactly the one cycle after the performing edge. Total latency: accepted at edge k, ready_o high after edge k+LATENCY-1. LATENCY=1 therefore matches the previous synchronous-read timing.
- Back-to-back: state is already IDLE while ready_o=1, so a new request can be accepted in that same cycle. Throughput is one access per LATENCY cycles.
- Inputs while in WAIT are ignored; no queueing.
- Error condition: addr[1:0]!=0 (misaligned) OR addr >= DEPTH_WORDS*4 (out of range). On error:
  - no RAM update;
  - read_data_o=ERR_VALUE, err_o=1, ready_o=1.
- Read (we=0, no error): read_data_o = word[addr>>2], err_o=0. Byte lanes are little-endian: lane i = byte addr+i = data[8i+7:8i].
- Write (we=1, no error): each lane i with be[i]=1 is updated from wdata[8i+7:8i]. read_data_o=IDLE_VALUE, err_o=0.
- be=4'b0000 write: RAM unchanged; a normal ready_o response is still given.
- Read after write: a read of the same word accepted in the write's response cycle returns the new data.
- Outside the response cycle: ready_o=0, err_o=0, read_data_o holds its last value.
- Width rule: word index = addr[$clog2(DEPTH_WORDS)+1:2]. Range check uses the full 32-bit addr, so there is no aliasing.

Decomposition:
- Package data_mem_pkg:
  - state enum (IDLE, WAIT);
  - default IDLE_VALUE and ERR_VALUE constants;
  - BYTES_PER_WORD=4.
- One sub-module, mem_be_array: synchronous word RAM with 4 byte write enables and registered read, parametrised by DEPTH_WORDS.
- The top level holds the FSM, latency counter, error check and response mux.

Test Plan:
- Reset, LATENCY=1: write 0x1122_3344 to 0x10 with be=4'hF, then read 0x10 -> ready_o one cycle after each accept; read returns 0x1122_3344, err_o=0; write response data = IDLE_VALUE.
- Byte enables: word 0x20 holds 0xAABB_CCDD; write 0x1122_3344 with be=4'b0101 -> read returns 0xAA22_CC44.
- LATENCY=3: hold mem_req_i high with changing addr -> ready_o exactly 3 cycles after each accept; second request accepted in the first ready cycle; mid-WAIT input changes have no effect.
- Errors, DEPTH_WORDS=1024: write to 0x1000, then read 0x0000_0002 -> both give ready_o=1, err_o=1, read_data_o=ERR_VALUE; word 0 and every other word unchanged.
- Reset during WAIT with LATENCY=4 on a write to 0x40 -> no ready_o pulse; read 0x40 returns the pre-write value; outputs return to reset values.
- be=0 write to 0x8 -> ready_o=1, err_o=0; contents unchanged.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the latency-configurable data memory.
package data_mem_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;

    localparam logic [31:0] DEF_IDLE_VALUE = 32'hFA11_1EAF;
    localparam logic [31:0] DEF_ERR_VALUE  = 32'hDEAD_BEEF;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Source of read_data_o for the current/last response.
    typedef enum logic [1:0] {
        RESP_IDLE = 2'd0,
        RESP_ERR  = 2'd1,
        RESP_RAM  = 2'd2
    } resp_sel_t;

    // Captured access request.
    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_be_array.sv
// Synchronous word RAM with per-byte write enables and a registered read port.
module mem_be_array
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Byte-lane writes; read register only updates on a read so it holds between reads.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < int'(BYTES_PER_WORD); i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (en && !we) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/data_mem_lat.sv
// Word-organised data RAM with configurable access latency and ready/error response.
module data_mem_lat
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1,
    parameter logic [31:0] IDLE_VALUE  = DEF_IDLE_VALUE,
    parameter logic [31:0] ERR_VALUE   = DEF_ERR_VALUE
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_req_i,
    input  logic        write_enable_i,
    input  logic [3:0]  byte_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        ready_o,
    output logic        err_o
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam int unsigned CW        = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam int unsigned BYTE_SPAN = DEPTH_WORDS * BYTES_PER_WORD;
    localparam logic [32:0] ADDR_LIMIT = 33'(BYTE_SPAN);
    localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? (LATENCY - 2) : 0);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    mem_req_t      held, cur;
    logic          accept, perform, access_err, ram_en;
    resp_sel_t     resp_sel;
    logic [31:0]   ram_rdata;

    // Next-state, counter and perform decode; live inputs in IDLE, captured request in WAIT.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        perform  = 1'b0;
        cur      = held;
        case (state)
            IDLE: begin
                cur = '{we: write_enable_i, be: byte_enable_i,
                        addr: addr_i, wdata: write_data_i};
                if (mem_req_i) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        perform = 1'b1;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    perform  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Misaligned or beyond the array (full 32-bit compare, no aliasing).
    always_comb begin
        access_err = (cur.addr[1:0] != 2'b00) || ({1'b0, cur.addr} >= ADDR_LIMIT);
        ram_en     = perform && !access_err && !rst_i;
    end

    // FSM state and latency counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Request capture at the accepting edge.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            held <= cur;
        end
    end

    // One-cycle response pulse and selection of the read data source.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_o  <= 1'b0;
            err_o    <= 1'b0;
            resp_sel <= RESP_IDLE;
        end else begin
            ready_o <= perform;
            err_o   <= perform && access_err;
            if (perform) begin
                if (access_err) begin
                    resp_sel <= RESP_ERR;
                end else if (cur.we) begin
                    resp_sel <= RESP_IDLE;
                end else begin
                    resp_sel <= RESP_RAM;
                end
            end
        end
    end

    // Read data mux over registered sources.
    always_comb begin
        case (resp_sel)
            RESP_ERR: read_data_o = ERR_VALUE;
            RESP_RAM: read_data_o = ram_rdata;
            default:  read_data_o = IDLE_VALUE;
        endcase
    end

    mem_be_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk   (clk_i),
        .en    (ram_en),
        .we    (cur.we),
        .be    (cur.be),
        .idx   (cur.addr[AW+1:2]),
        .wdata (cur.wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_data_mem_lat.sv
// Scoreboard bench for data_mem_lat: three instances with LATENCY 1, 3 and 4.
module tb_data_mem_lat;

    localparam logic [31:0] IDLE_V = 32'hFA11_1EAF;
    localparam logic [31:0] ERR_V  = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst   [3];
    logic        req   [3];
    logic        we    [3];
    logic [3:0]  be    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        ready [3];
    logic        err   [3];

    exp_t sb [3][$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_lat #(.DEPTH_WORDS(1024), .LATENCY(1)) u_lat1 (
        .clk_i(clk), .rst_i(rst[0]), .mem_req_i(req[0]), .write_enable_i(we[0]),
        .byte_enable_i(be[0]), .addr_i(addr[0]), .write_data_i(wdata[0]),
        .read_data_o(rdata[0]), .ready_o(ready[0]), .err_o(err[0]));

    data_mem_lat #(.DEPTH_WORDS(1024), .LATENCY(3)) u_lat3 (
        .clk_i(clk), .rst_i(rst[1]), .mem_req_i(req[1]), .write_enable_i(we[1]),
        .byte_enable_i(be[1]), .addr_i(addr[1]), .write_data_i(wdata[1]),
        .read_data_o(rdata[1]), .ready_o(ready[1]), .err_o(err[1]));

    data_mem_lat #(.DEPTH_WORDS(1024), .LATENCY(4)) u_lat4 (
        .clk_i(clk), .rst_i(rst[2]), .mem_req_i(req[2]), .write_enable_i(we[2]),
        .byte_enable_i(be[2]), .addr_i(addr[2]), .write_data_i(wdata[2]),
        .read_data_o(rdata[2]), .ready_o(ready[2]), .err_o(err[2]));

    function automatic int lat_of(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    // Monitor: every ready pulse must match the oldest expected response, including its cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ready[i] === 1'b1) begin
                exp_t e;
                n_cmp++;
                if (sb[i].size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_ready inst%0d cyc=%0d data=%h err=%b",
                             i, cyc, rdata[i], err[i]);
                end else begin
                    e = sb[i].pop_front();
                    if (rdata[i] !== e.data || err[i] !== e.err || cyc != e.cyc) begin
                        n_bad++;
                        $display("FAIL resp inst%0d got data=%h err=%b cyc=%0d want data=%h err=%b cyc=%0d",
                                 i, rdata[i], err[i], cyc, e.data, e.err, e.cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // Drive one request at a negedge, queue its response, and return in its response cycle.
    // Between acceptance and response the inputs are scrambled (req held high) to prove they are ignored.
    task automatic issue(input int i, input logic w, input logic [3:0] b, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] xd, input logic xe);
        exp_t e;
        int   lat;
        lat      = lat_of(i);
        req[i]   = 1'b1;
        we[i]    = w;
        be[i]    = b;
        addr[i]  = a;
        wdata[i] = d;
        e.data   = xd;
        e.err    = xe;
        e.cyc    = cyc + lat;
        sb[i].push_back(e);
        for (int j = 0; j < lat; j++) begin
            @(negedge clk);
            if (j < lat - 1) begin
                we[i]    = 1'b1;
                be[i]    = 4'hF;
                addr[i]  = 32'h0000_0100;
                wdata[i] = 32'hBAD0_0000 | 32'(j);
            end
        end
    endtask

    task automatic idle(input int i);
        req[i]   = 1'b0;
        we[i]    = 1'b0;
        be[i]    = 4'h0;
        addr[i]  = '0;
        wdata[i] = '0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0;
            be[i] = 4'h0; addr[i] = '0; wdata[i] = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_rdata%0d", i), rdata[i], IDLE_V);
            chk($sformatf("reset_rdy_err%0d", i), {30'd0, ready[i], err[i]}, 32'd0);
            rst[i] = 1'b0;
        end
        @(negedge clk);

        // LATENCY=1: write/read, back-to-back read-after-write, byte lanes
        issue(0, 1'b1, 4'hF, 32'h10, 32'h1122_3344, IDLE_V, 1'b0);
        issue(0, 1'b0, 4'h0, 32'h10, 32'h0, 32'h1122_3344, 1'b0);
        issue(0, 1'b1, 4'hF, 32'h20, 32'hAABB_CCDD, IDLE_V, 1'b0);
        issue(0, 1'b1, 4'b0101, 32'h20, 32'h1122_3344, IDLE_V, 1'b0);
        issue(0, 1'b0, 4'h0, 32'h20, 32'h0, 32'hAA22_CC44, 1'b0);

        // Errors: out of range, misaligned, high-bit alias of word 4
        issue(0, 1'b1, 4'hF, 32'h0, 32'h0C0F_FEE0, IDLE_V, 1'b0);
        issue(0, 1'b1, 4'hF, 32'h1000, 32'hFFFF_FFFF, ERR_V, 1'b1);
        issue(0, 1'b0, 4'h0, 32'h2, 32'h0, ERR_V, 1'b1);
        issue(0, 1'b1, 4'hF, 32'h3, 32'h9999_9999, ERR_V, 1'b1);
        issue(0, 1'b1, 4'hF, 32'h8000_0010, 32'h7777_7777, ERR_V, 1'b1);
        issue(0, 1'b0, 4'h0, 32'h1000, 32'h0, ERR_V, 1'b1);
        issue(0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0C0F_FEE0, 1'b0);
        issue(0, 1'b0, 4'h0, 32'h10, 32'h0, 32'h1122_3344, 1'b0);
        issue(0, 1'b0, 4'h0, 32'h20, 32'h0, 32'hAA22_CC44, 1'b0);

        // be=0 write leaves the word untouched but still responds
        issue(0, 1'b1, 4'hF, 32'h8, 32'h55AA_55AA, IDLE_V, 1'b0);
        issue(0, 1'b1, 4'h0, 32'h8, 32'hFFFF_FFFF, IDLE_V, 1'b0);
        issue(0, 1'b0, 4'h0, 32'h8, 32'h0, 32'h55AA_55AA, 1'b0);
        idle(0);
        chk("hold_rdata", rdata[0], 32'h55AA_55AA);
        chk("hold_rdy_err", {30'd0, ready[0], err[0]}, 32'd0);

        // LATENCY=3: back-to-back with scrambled inputs during WAIT
        issue(1, 1'b1, 4'hF, 32'h100, 32'hA1A2_A3A4, IDLE_V, 1'b0);
        issue(1, 1'b1, 4'hF, 32'h104, 32'hB1B2_B3B4, IDLE_V, 1'b0);
        issue(1, 1'b0, 4'h0, 32'h100, 32'h0, 32'hA1A2_A3A4, 1'b0);
        issue(1, 1'b0, 4'h0, 32'h104, 32'h0, 32'hB1B2_B3B4, 1'b0);
        issue(1, 1'b0, 4'h0, 32'h2000, 32'h0, ERR_V, 1'b1);
        issue(1, 1'b0, 4'h0, 32'h100, 32'h0, 32'hA1A2_A3A4, 1'b0);
        idle(1);

        // LATENCY=4: reset during WAIT aborts a write with no response
        issue(2, 1'b1, 4'hF, 32'h40, 32'h1234_5678, IDLE_V, 1'b0);
        issue(2, 1'b0, 4'h0, 32'h40, 32'h0, 32'h1234_5678, 1'b0);
        req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF;
        addr[2] = 32'h40; wdata[2] = 32'hCAFE_F00D;
        @(negedge clk);
        rst[2] = 1'b1; req[2] = 1'b0;
        @(negedge clk);
        rst[2] = 1'b0;
        chk("abort_rdata", rdata[2], IDLE_V);
        chk("abort_rdy_err", {30'd0, ready[2], err[2]}, 32'd0);
        repeat (6) @(negedge clk);
        issue(2, 1'b0, 4'h0, 32'h40, 32'h0, 32'h1234_5678, 1'b0);
        idle(2);

        repeat (6) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("sb_empty%0d", i), 32'(sb[i].size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
